// File: rtl/cpp_double_to_bool_sched.sv
// cpp_double_to_bool_sched
// Shares a single double-to-bool hysteresis comparator among NCH channels.
// Each channel signals a new 64-bit IEEE-754 sample by toggling its
// update_in line. The sample is captured into a per-channel register and
// marked pending. A round-robin arbiter grants one pending channel per
// cycle to the shared comparator, which updates that channel's out bit and
// copies the captured toggle value to update_out.
//
// Handshake: there is no ready/backpressure. A producer may toggle
// update_in[i] on any cycle (clk-synchronous). If channel i already has an
// unconverted sample and it is not granted on that edge, the new sample
// replaces the old one (coalescing) and overrun[i] is set. Completion is
// signalled by update_out[i] taking the captured update_in[i] value.
//
// Optional build macro: DBL2BOOL_SCHED_STATS_EN adds ovr_cnt, a per-channel
// saturating 8-bit overwrite counter.
module cpp_double_to_bool_sched #(
  parameter int          NCH       = 4,
  parameter logic [63:0] THRESH_HI = 64'h3F847AE147AE147B,
  parameter logic [63:0] THRESH_LO = 64'h3F847AE147AE147B
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [64*NCH-1:0] in,
  input  logic [NCH-1:0]    update_in,
  output logic [NCH-1:0]    out,
  output logic [NCH-1:0]    update_out,
  output logic [NCH-1:0]    overrun,
  input  logic              ovr_clr,
  output logic              busy
`ifdef DBL2BOOL_SCHED_STATS_EN
  ,
  output logic [8*NCH-1:0]  ovr_cnt
`endif
);

  localparam int RRW = (NCH > 1) ? $clog2(NCH) : 1;

  // Map a double bit pattern onto an unsigned key whose ordering matches the
  // numeric ordering of non-NaN doubles. Both zeros map to the same key.
  function automatic logic [63:0] dbl_key(input logic [63:0] v);
    logic [63:0] k;
    if (v[62:0] == 63'd0) begin
      k = 64'h8000_0000_0000_0000;
    end else if (!v[63]) begin
      k = {1'b1, v[62:0]};
    end else begin
      k = {1'b0, ~v[62:0]};
    end
    return k;
  endfunction

  function automatic logic dbl_is_nan(input logic [63:0] v);
    return (v[62:52] == 11'h7FF) && (v[51:0] != 52'd0);
  endfunction

  // State registers
  logic [NCH-1:0] upd_prev_q, upd_prev_d;
  logic [NCH-1:0] pending_q,  pending_d;
  logic [NCH-1:0] tag_q,      tag_d;
  logic [NCH-1:0] out_q,      out_d;
  logic [NCH-1:0] uo_q,       uo_d;
  logic [NCH-1:0] ovr_q,      ovr_d;
  logic [RRW-1:0] rr_q,       rr_d;
  logic [63:0]    sample_q [NCH];
  logic [63:0]    sample_d [NCH];

  // Combinational helpers
  logic [NCH-1:0] evt;
  logic [NCH-1:0] ovr_set;
  logic [NCH-1:0] grant_oh;
  logic           grant_vld;
  logic [RRW-1:0] grant_idx;
  logic [63:0]    conv_sample;
  logic           conv_rise;
  logic           conv_fall;

  assign evt = update_in ^ upd_prev_q;

  // Round-robin arbiter: first pending channel searching upward from rr+1.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = rr_q;
    grant_oh  = '0;
    idx       = 0;
    for (int k = 1; k <= NCH; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!grant_vld && pending_q[idx]) begin
        grant_vld     = 1'b1;
        grant_idx     = idx[RRW-1:0];
        grant_oh[idx] = 1'b1;
      end
    end
  end

  // The single shared comparator, fed by the granted channel's sample.
  always_comb begin
    conv_sample = sample_q[grant_idx];
    conv_rise   = !dbl_is_nan(conv_sample) &&
                  (dbl_key(conv_sample) > dbl_key(THRESH_HI));
    conv_fall   = !dbl_is_nan(conv_sample) &&
                  (dbl_key(conv_sample) <= dbl_key(THRESH_LO));
  end

  // Next-state: capture, conversion of the granted channel, overrun.
  always_comb begin
    upd_prev_d = update_in;
    pending_d  = pending_q;
    tag_d      = tag_q;
    out_d      = out_q;
    uo_d       = uo_q;
    ovr_set    = '0;
    rr_d       = grant_vld ? grant_idx : rr_q;
    for (int i = 0; i < NCH; i++) begin
      sample_d[i] = sample_q[i];
    end
    for (int i = 0; i < NCH; i++) begin
      if (grant_oh[i]) begin
        if (!out_q[i] && conv_rise) out_d[i] = 1'b1;
        if (out_q[i] && conv_fall)  out_d[i] = 1'b0;
        uo_d[i]      = tag_q[i];
        pending_d[i] = 1'b0;
      end
      if (evt[i]) begin
        sample_d[i]  = in[64*i +: 64];
        tag_d[i]     = update_in[i];
        pending_d[i] = 1'b1;
        if (pending_q[i] && !grant_oh[i]) ovr_set[i] = 1'b1;
      end
    end
    // A new overwrite on the same edge as a clear leaves the flag set.
    ovr_d = ovr_set | (ovr_q & {NCH{~ovr_clr}});
  end

  // Main state registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_prev_q <= '0;
      pending_q  <= '0;
      tag_q      <= '0;
      out_q      <= '0;
      uo_q       <= '0;
      ovr_q      <= '0;
      rr_q       <= RRW'(NCH - 1);
      for (int i = 0; i < NCH; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      upd_prev_q <= upd_prev_d;
      pending_q  <= pending_d;
      tag_q      <= tag_d;
      out_q      <= out_d;
      uo_q       <= uo_d;
      ovr_q      <= ovr_d;
      rr_q       <= rr_d;
      for (int i = 0; i < NCH; i++) begin
        sample_q[i] <= sample_d[i];
      end
    end
  end

  assign out        = out_q;
  assign update_out = uo_q;
  assign overrun    = ovr_q;
  assign busy       = |pending_q;

`ifdef DBL2BOOL_SCHED_STATS_EN
  logic [7:0] cnt_q [NCH];
  logic [7:0] cnt_d [NCH];

  // Saturating overwrite counters; an increment on a clear edge yields 1.
  always_comb begin
    logic [7:0] base;
    base = 8'd0;
    for (int i = 0; i < NCH; i++) begin
      base = ovr_clr ? 8'd0 : cnt_q[i];
      if (ovr_set[i] && (base != 8'hFF)) begin
        cnt_d[i] = base + 8'd1;
      end else begin
        cnt_d[i] = base;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Flatten the counters onto the output bus.
  always_comb begin
    ovr_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      ovr_cnt[8*i +: 8] = cnt_q[i];
    end
  end
`endif

endmodule

// File: doc/cpp_double_to_bool_sched.md
Name: cpp_double_to_bool_sched

Overview:
- Shares one double-to-bool hysteresis comparator among NCH channels.
- Each channel delivers a 64-bit IEEE-754 double with a toggle-style update event, i.e. any change on its update line.
- The block captures each sample, schedules conversions round-robin through the single comparator, and drives per-channel bool outputs with matching update toggles.
- It sits between the CppSim real-valued signal nets and the boolean consumers, replacing NCH standalone converters.

Parameters:
- NCH, 4, number of channels (2..16).
- THRESH_HI, 64'h3F847AE147AE147B, rise threshold (0.01). out goes 0->1 when sample > THRESH_HI.
- THRESH_LO, 64'h3F847AE147AE147B, fall threshold (0.01). out goes 1->0 when sample <= THRESH_LO. THRESH_LO <= THRESH_HI is required.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in  input  64*NCH  channel i double bit pattern at [64*i+63:64*i].
- update_in  input  NCH  per-channel toggle; any change = new sample event.
- out  output  NCH  per-channel boolean result.
- update_out  output  NCH  per-channel toggle; copies the captured update_in value when that channel's conversion completes.
- overrun  output  NCH  sticky: a sample was overwritten before it was converted.
- ovr_clr  input  1  synchronous clear of overrun (and of ovr_cnt when present).
- busy  output  1  OR of all pending flags.

Behaviour:
- Reset (async, rst_n=0):
  - out=0, update_out=0, overrun=0, busy=0.
  - Internal: upd_prev=0, pending=0, sample regs=0, tag=0, rr pointer=NCH-1 so channel 0 has first priority.
- Event detect: evt[i] = update_in[i] ^ upd_prev[i]. Every edge loads upd_prev <= update_in. update_in must be clk-synchronous.
- Capture, on an edge with evt[i]=1:
  - sample[i] <= in[i]
  - tag[i] <= update_in[i]
  - pending[i] <= 1
- Arbitration, each edge:
  - Grant the first pending channel searching from rr+1 upward, wrapping at NCH-1 -> 0.
  - At most one grant per cycle. rr <= granted index. If no channel is pending, no grant and rr holds.
- Convert, granted channel g, same edge:
  - Use the registered sample[g] and tag[g].
  - If out[g]=0 and sample > THRESH_HI: out[g] <= 1.
  - If out[g]=1 and sample <= THRESH_LO: out[g] <= 0.
  - Otherwise out[g] holds.
  - update_out[g] <= tag[g]. pending[g] <= 0 unless evt[g]=1 on this edge.
- Latency:
  - Uncontended: capture at edge k, out/update_out valid after edge k+1.
  - Worst case: capture at edge k, complete after edge k+NCH.
- Double compare:
  - Sign-magnitude ordering on the bit pattern; +0 and -0 compare equal.
  - Infinities are ordered normally.
  - NaN (exp=7FF, mantissa!=0) satisfies neither condition, so out holds. update_out still toggles.
- Simultaneous events:
  - evt[i] on the edge channel i is granted: the old sample converts, the new sample is captured, and pending stays 1.
  - evt[i] while pending[i]=1 and i is not granted: the sample and tag are overwritten and overrun[i] <= 1. This coalesces the events, so update_out later shows the latest tag.
- overrun: set wins over ovr_clr on the same edge.
- busy = |pending, registered view.
- Reset mid-operation: all pending conversions are discarded and outputs return to 0 immediately.

Optional Feature:
- DBL2BOOL_SCHED_STATS_EN defined:
  - Adds output ovr_cnt, 8*NCH bits: per-channel saturating 8-bit overrun counter.
  - Increments on each overwrite event and saturates at 255.
  - Cleared by ovr_clr (increment wins on the same edge, giving 1) and reset to 0.
- Undefined: port ovr_cnt and its counters are absent; all other behaviour is identical.

Test Plan:
- Single event: ch0 in=64'h3FE0000000000000 (0.5), toggle update_in[0] 0->1 at edge k -> out[0]=1 and update_out[0]=1 after edge k+1, busy=0 after edge k+1.
- Hysteresis boundary: out[1]=1; ch1 in=64'h3F847AE147AE147B (exactly 0.01), toggle -> out[1]=0. Re-send the same value -> out[1] stays 0, since > is required to rise. Then in=64'hBFF0000000000000 (-1.0) -> stays 0.
- Round-robin contention: all 4 channels toggle on the same edge k with 0.5 -> completions in order 0,1,2,3 after edges k+1..k+4. The next simultaneous burst is served starting at ch0, because rr=3.
- Overrun: ch2 toggles at edges k and k+1 while ch0/ch1 are pending ahead -> one ch2 conversion of the second sample, overrun[2]=1, ovr_cnt[2]=1 with the macro. ovr_clr -> overrun[2]=0.
- NaN and zero: in=64'h7FF8000000000000 with out=1 -> out stays 1 and update_out toggles. in=64'h8000000000000000 (-0.0) -> out=0.
- Async reset: assert rst_n=0 mid-burst with 3 pending -> out, update_out, overrun and busy go to 0 without a clock. After release, no conversions occur until new toggles arrive.
